// File: rtl/mux_pkg.sv
// Select encoding shared by the 4-to-1 mux family.
// Bit 1 of the select is s1 (MSB) and bit 0 is s0 (LSB).
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux_4x1_core.sv
// Pure combinational WIDTH-bit one-of-four selector.
// A select that matches no code (X/Z in simulation) yields all zeros.
module mux_4x1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux_4x1.sv
// 4-to-1 selector with an optional output register.
// REGISTERED=1 gives one clock of latency with a synchronous active-low reset.
module mux_4x1
  import mux_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_d;
  sel_t             sel;

  assign sel = {s1, s0};

  mux_4x1_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .sel(sel),
    .y  (out_d)
  );

  generate
    if (REGISTERED != 0) begin : g_reg
      logic [WIDTH-1:0] out_q;

      // Reset wins over the data path on the same edge.
      always_ff @(posedge clk) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
      end

      assign out = out_q;
    end else begin : g_comb
      // Clock and reset are intentionally left without a load here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out            = out_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: table vectors, exhaustive sweep, toggling,
// reset corners, a combinational build and randomized wide checks.
module tb_mux_4x1;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 registered instance
  logic rst1, a1, b1, c1, d1, s01, s11, out1;
  // WIDTH=4 combinational instance
  logic [3:0] ca, cb, cc, cd, cout;
  logic cs0, cs1, crst;
  // WIDTH=8 registered instance
  logic r8, s08, s18;
  logic [7:0] a8, b8, c8, d8, out8;

  mux_4x1 #(.WIDTH(1), .REGISTERED(1)) dut1 (
    .clk(clk), .rst_n(rst1), .a(a1), .b(b1), .c(c1), .d(d1),
    .s0(s01), .s1(s11), .out(out1)
  );

  mux_4x1 #(.WIDTH(4), .REGISTERED(0)) dut4c (
    .clk(clk), .rst_n(crst), .a(ca), .b(cb), .c(cc), .d(cd),
    .s0(cs0), .s1(cs1), .out(cout)
  );

  mux_4x1 #(.WIDTH(8), .REGISTERED(1)) dut8 (
    .clk(clk), .rst_n(r8), .a(a8), .b(b8), .c(c8), .d(d8),
    .s0(s08), .s1(s18), .out(out8)
  );

  int tests = 0;
  int fails = 0;

  // Reference: the four inputs form an indexable pool, the select is the index.
  function automatic logic [7:0] ref_pick(input logic [7:0] pa, input logic [7:0] pb,
                                          input logic [7:0] pc, input logic [7:0] pd,
                                          input logic [1:0] sel);
    logic [7:0] pool [4];
    pool[0] = pa;
    pool[1] = pb;
    pool[2] = pc;
    pool[3] = pd;
    return pool[sel];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: out=%h expected=%h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: out=%h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic r, input logic pa, input logic pb, input logic pc,
                        input logic pd, input logic [1:0] sel);
    rst1 = r; a1 = pa; b1 = pb; c1 = pc; d1 = pd;
    {s11, s01} = sel;
  endtask

  typedef struct packed {
    logic       rst_n;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic [1:0] sel;
    logic       exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] e;
    logic [5:0] bits;

    // Reset for two edges, release, then the select sweep.
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1};

    drive1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
    crst = 1'b1; ca = '0; cb = '0; cc = '0; cd = '0; cs0 = 1'b0; cs1 = 1'b0;
    r8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF; s08 = 1'b1; s18 = 1'b1;
    #1;

    for (int i = 0; i < 7; i++) begin
      drive1(vecs[i].rst_n, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].sel);
      tick();
      check($sformatf("table[%0d]", i), {7'd0, out1}, {7'd0, vecs[i].exp});
    end
    check("reset8", out8, 8'h00);

    // Exhaustive: all 64 combinations of {a,b,c,d,s1,s0}.
    for (int i = 0; i < 64; i++) begin
      bits = i[5:0];
      drive1(1'b1, bits[5], bits[4], bits[3], bits[2], bits[1:0]);
      e = ref_pick({7'd0, a1}, {7'd0, b1}, {7'd0, c1}, {7'd0, d1}, {s11, s01});
      tick();
      check($sformatf("exh[%0d]", i), {7'd0, out1}, e);
    end

    // Between-edge input changes must not reach out.
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    tick();
    check("hold_pre", {7'd0, out1}, 8'h01);
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    #3;
    check("hold_mid", {7'd0, out1}, 8'h01);
    tick();
    check("hold_post", {7'd0, out1}, 8'h00);

    // Mid-operation reset with d=1 streaming on sel=11; reset is not asynchronous.
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    tick();
    check("midrst_run", {7'd0, out1}, 8'h01);
    rst1 = 1'b0;
    #3;
    check("midrst_async", {7'd0, out1}, 8'h01);
    tick();
    check("midrst_low", {7'd0, out1}, 8'h00);
    rst1 = 1'b1;
    tick();
    check("midrst_release", {7'd0, out1}, 8'h01);

    // Toggling stimulus; toggles are offset from the rising edges.
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    fork
      begin
        for (int n = 1; n <= 100; n++) begin
          #5;
          d1 = ~d1;
          if (n % 2 == 0)  c1  = ~c1;
          if (n % 4 == 0)  b1  = ~b1;
          if (n % 8 == 0)  a1  = ~a1;
          if (n % 16 == 0) s01 = ~s01;
          if (n % 32 == 0) s11 = ~s11;
        end
      end
      begin
        logic [7:0] te;
        for (int k = 0; k < 50; k++) begin
          @(posedge clk);
          te = ref_pick({7'd0, a1}, {7'd0, b1}, {7'd0, c1}, {7'd0, d1}, {s11, s01});
          #1;
          check($sformatf("toggle[%0d]", k), {7'd0, out1}, te);
        end
      end
    join

    // Combinational build: no clock edge needed.
    ca = 4'h3; cb = 4'hA; cc = 4'h5; cd = 4'hF; {cs1, cs0} = 2'b10;
    #1;
    check("comb_sel10", {4'd0, cout}, 8'h05);
    {cs1, cs0} = 2'b11;
    #1;
    check("comb_sel11", {4'd0, cout}, 8'h0F);
    crst = 1'b0;
    #1;
    check("comb_rst_ignored", {4'd0, cout}, 8'h0F);
    for (int i = 0; i < 16; i++) begin
      ca = 4'($urandom); cb = 4'($urandom); cc = 4'($urandom); cd = 4'($urandom);
      {cs1, cs0} = 2'($urandom);
      #1;
      e = ref_pick({4'd0, ca}, {4'd0, cb}, {4'd0, cc}, {4'd0, cd}, {cs1, cs0});
      check($sformatf("comb_rand[%0d]", i), {4'd0, cout}, e);
    end

    // Randomized WIDTH=8 registered checks with occasional reset.
    for (int i = 0; i < 120; i++) begin
      r8 = ($urandom % 8) != 0;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      s08 = 1'($urandom); s18 = 1'($urandom);
      e = r8 ? ref_pick(a8, b8, c8, d8, {s18, s08}) : 8'h00;
      tick();
      check($sformatf("w8_rand[%0d]", i), out8, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
Registered 4-to-1 selector. One of four data inputs (a, b, c, d) is chosen by the two select bits {s1, s0} and presented on out. It is a leaf utility block used wherever a datapath needs a one-of-four pick with a clean, glitch-free registered output. A parameter lets the same block be built as a purely combinational mux.

Parameters:
WIDTH, 1, bit width of each data input and of out.
REGISTERED, 1, 1 = out is registered (1-cycle latency); 0 = out is combinational, and clk/rst_n are unused.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset; sampled on the rising clk edge.
a  input  WIDTH  data input 0, selected when {s1,s0}=2'b00.
b  input  WIDTH  data input 1, selected when {s1,s0}=2'b01.
c  input  WIDTH  data input 2, selected when {s1,s0}=2'b10.
d  input  WIDTH  data input 3, selected when {s1,s0}=2'b11.
s0  input  1  select LSB.
s1  input  1  select MSB.
out  output  WIDTH  selected data.

Behaviour:
- Select map, with s1 as the MSB: 00 -> a, 01 -> b, 10 -> c, 11 -> d.
- Selection logic: full case with no latch inferred. Any non-0/1 select value (X/Z in simulation) drives the mux result to all zeros.
- REGISTERED=1:
  - On each rising clk with rst_n=1, out <= mux(a,b,c,d,{s1,s0}).
  - Latency: exactly 1 clock from a data or select change to out.
  - Inputs changing between edges have no effect on out.
- Reset (REGISTERED=1):
  - rst_n=0 at a rising edge forces out = {WIDTH{1'b0}}.
  - Asserting rst_n has no effect between edges (synchronous only).
  - Reset takes priority over the data path.
  - On the first edge with rst_n=1, out takes the current mux result.
- REGISTERED=0:
  - out = mux(...) continuously, with zero delay.
  - clk and rst_n are ignored, and no flops are inferred.
- Simultaneous data and select change before an edge: out takes the value selected by the new select applied to the new data.
- WIDTH: all data bits are selected uniformly, bit i of out comes from bit i of the chosen input, and there is no width conversion.

Decomposition:
- Shared package mux_pkg holds the select encoding constants: SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
- One natural sub-module, mux_4x1_core: the pure combinational WIDTH-bit selector. The top adds the optional output register via a generate on REGISTERED.

Test Plan:
- Reset: rst_n=0 for 2 edges with a=1,b=1,c=1,d=1, sel=11 -> out=0. Release rst_n -> out=1 one edge later.
- Select sweep (WIDTH=1): a=0,b=1,c=0,d=1. Step {s1,s0} through 00,01,10,11 on successive edges -> out = 0,1,0,1, each 1 clock after its select.
- Exhaustive: all 64 combinations of a,b,c,d,s0,s1, each held 1 clock. Check out against the reference model, 1 clock later.
- Toggling stimulus: a toggles every 40 time units, b every 20, c every 10, d every 5, s0 every 80, s1 every 160, for 500 time units. Sample on every clk edge -> out equals the prior-cycle selected input.
- Mid-operation reset: with sel=11 and d=1 streaming, assert rst_n=0 for one edge -> out=0 that cycle, then out=d one cycle after release.
- REGISTERED=0, WIDTH=4: a=4'h3,b=4'hA,c=4'h5,d=4'hF, sel=10 -> out=4'h5 with no clock. Change sel to 11 -> out=4'hF immediately.
